gray_sync_rx: RTL and testbench
===============================

# gray_sync_rx

Receive-side stage for a free-running Gray-code counter whose output is asynchronous to the local clock. It synchronizes the Gray value, converts it to binary and validates that every observed change is a single forward step. It accumulates the forward steps and hands them to a local consumer over a valid/ready handshake. It sits directly downstream of the team's Gray counter blocks.

## Interface

Parameters:
- W, 4: Gray/binary width of the monitored counter (W >= 2).
- CW, 8: width of the step-count accumulator and of ev_count (CW >= 2).

Ports:
- clk  in  1  local clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- gray_in  in  W  Gray count from the foreign domain; asynchronous; at most one bit changes per transition.
- clear  in  1  synchronous re-arm; see Operation.
- ev_ready  in  1  consumer accepts the current event.
- ev_valid  out  1  event pending on ev_count.
- ev_count  out  CW  number of forward steps in this event; nonzero whenever ev_valid=1.
- pos  out  W  binary value of the last sampled Gray count.
- err  out  1  sticky: an illegal transition was observed.
- ovf  out  1  sticky: the accumulator saturated and steps were lost.

## Operation

- Synchronizer: s1 <= gray_in, s2 <= s1. Only s2 is used downstream.
- prev: register holding the last sampled Gray value. It loads s2 every cycle. pos = de-gray(prev), combinational from prev.
- Per-cycle classification of d = s2 ^ prev:
  - d == 0: no step, inc = 0.
  - Exactly one bit set and bin(s2) == bin(prev)+1 mod 2^W: forward step, inc = 1. Wrap from 2^W-1 to 0 is legal.
  - Exactly one bit set but a backward step: err <= 1, inc = 0.
  - Two or more bits set: err <= 1, inc = 0. prev still resynchronizes to s2.
- Accumulator pend (CW bits) and an output FSM with two states:
  - IDLE (ev_valid=0):
    - If pend+inc != 0: ev_count <= pend+inc, pend <= 0, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD (ev_valid=1, ev_count stable):
    - If ev_ready=1 and pend+inc != 0: reload ev_count <= pend+inc, pend <= 0, stay in HOLD. This gives back-to-back events.
    - If ev_ready=1 and pend+inc == 0: go to IDLE.
    - If ev_ready=0: pend <= sat(pend+inc).
- Saturation: pend never exceeds 2^CW-1. An increment at the maximum is dropped and sets ovf <= 1.
- clear (highest priority after reset), in the same cycle:
  - prev <= s2, pend <= 0, FSM -> IDLE, err <= 0, ovf <= 0.
  - Steps classified in the clear cycle are discarded.
  - s1 and s2 are unaffected.
- Reset (rst_n=0, any time, including mid-handshake): s1, s2, prev, pend, ev_count = 0; FSM = IDLE; ev_valid, err, ovf = 0; pos = 0.

## Timing

- Latency: gray_in stable before edge k -> s1 at k, s2 at k+1, classified in the cycle after k+1.
  - In IDLE: ev_valid=1 and pos updated after edge k+2.
  - err rises after edge k+2.
- Handshake: an event transfers on any edge where ev_valid && ev_ready. ev_count must not change while ev_valid=1 && ev_ready=0.
- ev_valid is independent of ev_ready combinationally. No combinational path from any input to any output.
- Throughput: one event per cycle while ev_ready=1. No steps are lost unless ovf is set.
- gray_in must change no faster than once every 2 clk cycles. Faster changes are reported as err, not silently miscounted.
- clear and ev_ready together in HOLD: clear wins, and the event is dropped.

## Test plan

- Reset, then gray_in=0000 held and ev_ready=1 for 20 cycles -> ev_valid, ev_count, pos, err and ovf stay 0.
- ev_ready=1, gray_in 0000->0001 -> ev_valid high for exactly 1 cycle after edge k+2 with ev_count=1; pos=1; err=0.
- ev_ready=0, five forward Gray steps 0->1->3->2->6->7 spaced 3 cycles -> ev_count=1 held stable; raise ev_ready -> next event ev_count=4; pos=5.
- Wrap, W=4: step gray 1000 (bin 15) -> 0000 -> count 1, pos=0, err=0. Backward step 0001->0000 -> err=1, no event.
- Jump 0000->0011 -> err=1, no event, pos=2; assert clear -> err=0. Next single step 0011->0010 counts 1.
- CW=3, ev_ready=0, 9 forward steps -> first event ev_count=1, pend saturates at 7, ovf=1; ready -> ev_count=7. Then pull rst_n low mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/gray_sync_rx_if.sv
// Bundle of the Gray-count input, re-arm control and event handshake for gray_sync_rx.
// master drives the Gray count and consumer side; slave is the receiver.
interface gray_sync_rx_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    logic [W-1:0]  gray_in;
    logic          clear;
    logic          ev_ready;
    logic          ev_valid;
    logic [CW-1:0] ev_count;
    logic [W-1:0]  pos;
    logic          err;
    logic          ovf;

    modport master (
        output gray_in, clear, ev_ready,
        input  ev_valid, ev_count, pos, err, ovf
    );

    modport slave (
        input  gray_in, clear, ev_ready,
        output ev_valid, ev_count, pos, err, ovf
    );
endinterface

// File: rtl/gray_sync_rx.sv
// Synchronizes a foreign Gray count, checks that each change is one forward step,
// and reports accumulated forward steps as events over a valid/ready handshake.
module gray_sync_rx #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_sync_rx_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    logic [W-1:0]  s1_r, s2_r, prev_r;
    logic [CW-1:0] pend_r, ev_count_r;
    logic          err_r, ovf_r;
    state_t        state_r;

    logic [W-1:0]  diff_s, bin_prev_s, bin_next_s;
    logic          fwd_s, bad_s;
    logic [CW:0]   sum_s;
    logic [CW-1:0] sat_s;
    logic          sum_nz_s, sum_ovf_s;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic is_onehot(input logic [W-1:0] v);
        return (v != {W{1'b0}}) && ((v & (v - {{(W-1){1'b0}}, 1'b1})) == {W{1'b0}});
    endfunction

    // Classify the current synchronized sample against the previous one and form the saturated sum.
    always_comb begin
        diff_s     = s2_r ^ prev_r;
        bin_prev_s = gray2bin(prev_r);
        bin_next_s = bin_prev_s + {{(W-1){1'b0}}, 1'b1};
        fwd_s      = 1'b0;
        if (is_onehot(diff_s) && (gray2bin(s2_r) == bin_next_s)) begin
            fwd_s = 1'b1;
        end else begin
            fwd_s = 1'b0;
        end
        bad_s     = (diff_s != {W{1'b0}}) && !fwd_s;
        sum_s     = {1'b0, pend_r} + {{CW{1'b0}}, fwd_s};
        sum_nz_s  = (sum_s != {(CW+1){1'b0}});
        sum_ovf_s = sum_s[CW];
        if (sum_ovf_s) begin
            sat_s = {CW{1'b1}};
        end else begin
            sat_s = sum_s[CW-1:0];
        end
    end

    // Synchronizer, sample history, sticky flags and the event output FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r       <= {W{1'b0}};
            s2_r       <= {W{1'b0}};
            prev_r     <= {W{1'b0}};
            pend_r     <= {CW{1'b0}};
            ev_count_r <= {CW{1'b0}};
            err_r      <= 1'b0;
            ovf_r      <= 1'b0;
            state_r    <= IDLE;
        end else begin
            s1_r   <= bus.gray_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            if (bus.clear) begin
                // Re-arm: anything classified this cycle, including a held event, is dropped.
                pend_r  <= {CW{1'b0}};
                err_r   <= 1'b0;
                ovf_r   <= 1'b0;
                state_r <= IDLE;
            end else begin
                if (bad_s) begin
                    err_r <= 1'b1;
                end
                case (state_r)
                    IDLE: begin
                        if (sum_nz_s) begin
                            ev_count_r <= sat_s;
                            pend_r     <= {CW{1'b0}};
                            state_r    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.ev_ready) begin
                            if (sum_nz_s) begin
                                ev_count_r <= sat_s;
                                pend_r     <= {CW{1'b0}};
                                if (sum_ovf_s) begin
                                    ovf_r <= 1'b1;
                                end
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            pend_r <= sat_s;
                            if (sum_ovf_s) begin
                                ovf_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ev_valid = (state_r == HOLD);
    assign bus.ev_count = ev_count_r;
    assign bus.pos      = gray2bin(prev_r);
    assign bus.err      = err_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx: one CW=8 and one CW=3 instance share the same stimulus.
module tb_gray_sync_rx;
    logic       clk;
    logic       rst_n;
    logic [3:0] gray;
    logic       clear;
    logic       ready;
    int         passed;
    int         total;
    logic [3:0] b;

    gray_sync_rx_if #(.W(4), .CW(8)) ifa ();
    gray_sync_rx_if #(.W(4), .CW(3)) ifb ();

    assign ifa.gray_in  = gray;
    assign ifa.clear    = clear;
    assign ifa.ev_ready = ready;
    assign ifb.gray_in  = gray;
    assign ifb.clear    = clear;
    assign ifb.ev_ready = ready;

    gray_sync_rx #(.W(4), .CW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    gray_sync_rx #(.W(4), .CW(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        gray   = 4'b0000;
        clear  = 1'b0;
        ready  = 1'b1;
        #3;
        check("rst_valid", {31'd0, ifa.ev_valid}, 32'd0);
        check("rst_count", {24'd0, ifa.ev_count}, 32'd0);
        check("rst_pos",   {28'd0, ifa.pos},      32'd0);
        tick(2);
        rst_n = 1'b1;

        // Idle with a constant count.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid", {31'd0, ifa.ev_valid}, 32'd0);
        end
        check("idle_count", {24'd0, ifa.ev_count}, 32'd0);
        check("idle_pos",   {28'd0, ifa.pos},      32'd0);
        check("idle_err",   {31'd0, ifa.err},      32'd0);
        check("idle_ovf",   {31'd0, ifa.ovf},      32'd0);

        // Single forward step 0000 -> 0001 with ready high.
        gray = 4'b0001;
        tick(2);
        check("step_early", {31'd0, ifa.ev_valid}, 32'd0);
        tick(1);
        check("step_valid", {31'd0, ifa.ev_valid}, 32'd1);
        check("step_count", {24'd0, ifa.ev_count}, 32'd1);
        check("step_pos",   {28'd0, ifa.pos},      32'd1);
        check("step_err",   {31'd0, ifa.err},      32'd0);
        tick(1);
        check("step_drop",  {31'd0, ifa.ev_valid}, 32'd0);

        // Backward step 0001 -> 0000.
        gray = 4'b0000;
        tick(3);
        check("back_err",   {31'd0, ifa.err},      32'd1);
        check("back_valid", {31'd0, ifa.ev_valid}, 32'd0);
        check("back_pos",   {28'd0, ifa.pos},      32'd0);
        pulse_clear();
        check("back_clear", {31'd0, ifa.err},      32'd0);

        // Five forward steps with ready low: first event held, four accumulated.
        ready = 1'b0;
        gray = 4'b0001; tick(3);
        gray = 4'b0011; tick(3);
        check("hold_c1", {24'd0, ifa.ev_count}, 32'd1);
        gray = 4'b0010; tick(3);
        gray = 4'b0110; tick(3);
        check("hold_c3", {24'd0, ifa.ev_count}, 32'd1);
        gray = 4'b0111; tick(3);
        check("hold_valid", {31'd0, ifa.ev_valid}, 32'd1);
        check("hold_count", {24'd0, ifa.ev_count}, 32'd1);
        check("hold_pos",   {28'd0, ifa.pos},      32'd5);
        ready = 1'b1;
        tick(1);
        check("b2b_valid", {31'd0, ifa.ev_valid}, 32'd1);
        check("b2b_count", {24'd0, ifa.ev_count}, 32'd4);
        tick(1);
        check("b2b_done",  {31'd0, ifa.ev_valid}, 32'd0);
        check("b2b_err",   {31'd0, ifa.err},      32'd0);

        // Jump to bin 15 (multi-bit), re-arm, then wrap 15 -> 0.
        gray = 4'b1000;
        tick(3);
        check("j15_err",   {31'd0, ifa.err},      32'd1);
        check("j15_valid", {31'd0, ifa.ev_valid}, 32'd0);
        check("j15_pos",   {28'd0, ifa.pos},      32'd15);
        pulse_clear();
        check("j15_clear", {31'd0, ifa.err},      32'd0);
        gray = 4'b0000;
        tick(3);
        check("wrap_valid", {31'd0, ifa.ev_valid}, 32'd1);
        check("wrap_count", {24'd0, ifa.ev_count}, 32'd1);
        check("wrap_pos",   {28'd0, ifa.pos},      32'd0);
        check("wrap_err",   {31'd0, ifa.err},      32'd0);
        tick(1);

        // Two-bit jump 0000 -> 0011, clear, then a legal step to 0010.
        gray = 4'b0011;
        tick(3);
        check("jmp_err",   {31'd0, ifa.err},      32'd1);
        check("jmp_valid", {31'd0, ifa.ev_valid}, 32'd0);
        check("jmp_pos",   {28'd0, ifa.pos},      32'd2);
        tick(1);
        check("jmp_novalid", {31'd0, ifa.ev_valid}, 32'd0);
        pulse_clear();
        check("jmp_clear", {31'd0, ifa.err}, 32'd0);
        gray = 4'b0010;
        tick(3);
        check("rearm_valid", {31'd0, ifa.ev_valid}, 32'd1);
        check("rearm_count", {24'd0, ifa.ev_count}, 32'd1);
        check("rearm_pos",   {28'd0, ifa.pos},      32'd3);
        tick(1);

        // Clear together with ready in HOLD drops the event.
        ready = 1'b0;
        gray = 4'b0110;
        tick(3);
        check("cr_valid", {31'd0, ifa.ev_valid}, 32'd1);
        ready = 1'b1;
        pulse_clear();
        check("cr_drop",  {31'd0, ifa.ev_valid}, 32'd0);
        tick(1);
        check("cr_idle",  {31'd0, ifa.ev_valid}, 32'd0);

        // Saturation: nine steps (bin 5..13) with ready low.
        ready = 1'b0;
        for (int k = 5; k <= 13; k++) begin
            b = 4'(k);
            gray = b ^ (b >> 1);
            tick(3);
        end
        check("sat_b_valid", {31'd0, ifb.ev_valid}, 32'd1);
        check("sat_b_count", {29'd0, ifb.ev_count}, 32'd1);
        check("sat_b_ovf",   {31'd0, ifb.ovf},      32'd1);
        check("sat_b_pos",   {28'd0, ifb.pos},      32'd13);
        check("sat_a_ovf",   {31'd0, ifa.ovf},      32'd0);
        ready = 1'b1;
        tick(1);
        check("sat_b_next", {29'd0, ifb.ev_count}, 32'd7);
        check("sat_a_next", {24'd0, ifa.ev_count}, 32'd8);
        tick(1);
        check("sat_b_done", {31'd0, ifb.ev_valid}, 32'd0);
        check("sat_b_err",  {31'd0, ifb.err},      32'd0);

        // Asynchronous reset in the middle of HOLD.
        ready = 1'b0;
        gray = 4'b1001;
        tick(3);
        check("pre_rst_valid", {31'd0, ifb.ev_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, ifb.ev_valid}, 32'd0);
        check("arst_count", {29'd0, ifb.ev_count}, 32'd0);
        check("arst_pos",   {28'd0, ifb.pos},      32'd0);
        check("arst_ovf",   {31'd0, ifb.ovf},      32'd0);
        check("arst_err",   {31'd0, ifb.err},      32'd0);
        check("arst_a_pos", {28'd0, ifa.pos},      32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
